// File: rtl/seq_alu_if.sv
// Operation/result handshake bundle for seq_alu.
// The master side issues operations and consumes results; the slave side is the ALU.
interface seq_alu_if #(
  parameter int BW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic [3:0]    opcode;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out;
  logic [3:0]    flags;

  modport master (
    output in_valid, in_a, in_b, opcode, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, in_a, in_b, opcode, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops plus an iterative shift-add multiplier.
// One result register with a valid/ready handshake; flags = {carry, overflow, negative, zero}.
module seq_alu #(
  parameter int BW = 16
) (
  input logic        clk,
  input logic        rst,
  seq_alu_if.slave   bus
);
  localparam int SW = $clog2(BW);
  localparam logic [SW-1:0] CNT_LAST = SW'(BW - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_INC  = 4'd5;
  localparam logic [3:0] OP_PSA  = 4'd6;
  localparam logic [3:0] OP_PSB  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_ASR  = 4'd11;
  localparam logic [3:0] OP_ADC  = 4'd12;

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  // Signed overflow of a+b: same-sign operands producing an opposite-sign result.
  function automatic logic add_ovf(input logic am, input logic bm, input logic rm);
    return (am == bm) && (rm != am);
  endfunction

  // Signed overflow of a-b: different-sign operands, result sign differs from a.
  function automatic logic sub_ovf(input logic am, input logic bm, input logic rm);
    return (am != bm) && (rm != am);
  endfunction

  // Assemble {carry, overflow, negative, zero} for a result.
  function automatic logic [3:0] pack_flags(input logic c, input logic v, input logic [BW-1:0] r);
    return {c, v, r[BW-1], (r == {BW{1'b0}})};
  endfunction

  state_t          state_r, state_nx_s;
  logic [SW-1:0]   cnt_r;
  logic            done_r;
  logic [2*BW-1:0] acc_r;
  logic [2*BW-1:0] mcand_r;
  logic [BW-1:0]   mplier_r;

  logic [BW-1:0]   out_r;
  logic [3:0]      flags_r;
  logic            out_valid_r;
  logic            carry_q_r;

  logic            in_ready_s;
  logic            accept_s;
  logic            alu_load_s;
  logic            mul_load_s;
  logic            load_s;

  logic [SW-1:0]   sh_s;
  logic [BW:0]     add_s, sub_s, inc_s, adc_s;
  logic [BW:0]     shl_s, shr_s, asr_s;
  logic [BW-1:0]   alu_res_s;
  logic            alu_c_s;
  logic            alu_v_s;
  logic [BW-1:0]   load_res_s;
  logic [3:0]      load_flags_s;

  assign in_ready_s = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign alu_load_s = accept_s && (bus.opcode != OP_MUL);
  // The product is final once done_r is set; it may only leave when the result register is free.
  assign mul_load_s = (state_r == MUL) && done_r && (!out_valid_r || bus.out_ready);
  assign load_s     = alu_load_s || mul_load_s;

  // All sums carry one extra bit so the carry-out falls out of bit BW.
  assign add_s = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign sub_s = {1'b0, bus.in_a} - {1'b0, bus.in_b};
  assign inc_s = {1'b0, bus.in_a} + {{BW{1'b0}}, 1'b1};
  assign adc_s = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{BW{1'b0}}, carry_q_r};

  // Shifts run on a one-bit-extended operand so the last bit shifted out lands in the
  // extension bit; a zero shift leaves the extension at 0, giving carry 0.
  assign sh_s  = bus.in_b[SW-1:0];
  assign shl_s = {1'b0, bus.in_a} << sh_s;
  assign shr_s = {bus.in_a, 1'b0} >> sh_s;
  assign asr_s = $signed({bus.in_a, 1'b0}) >>> sh_s;

  // Single-cycle result and carry/overflow for the presented opcode.
  always_comb begin
    alu_res_s = {BW{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        alu_res_s = add_s[BW-1:0];
        alu_c_s   = add_s[BW];
        alu_v_s   = add_ovf(bus.in_a[BW-1], bus.in_b[BW-1], add_s[BW-1]);
      end
      OP_SUB: begin
        alu_res_s = sub_s[BW-1:0];
        alu_c_s   = (bus.in_a < bus.in_b);
        alu_v_s   = sub_ovf(bus.in_a[BW-1], bus.in_b[BW-1], sub_s[BW-1]);
      end
      OP_AND: alu_res_s = bus.in_a & bus.in_b;
      OP_OR:  alu_res_s = bus.in_a | bus.in_b;
      OP_XOR: alu_res_s = bus.in_a ^ bus.in_b;
      OP_INC: begin
        alu_res_s = inc_s[BW-1:0];
        alu_c_s   = inc_s[BW];
        alu_v_s   = add_ovf(bus.in_a[BW-1], 1'b0, inc_s[BW-1]);
      end
      OP_PSA: alu_res_s = bus.in_a;
      OP_PSB: alu_res_s = bus.in_b;
      OP_SHL: begin
        alu_res_s = shl_s[BW-1:0];
        alu_c_s   = shl_s[BW];
      end
      OP_SHR: begin
        alu_res_s = shr_s[BW:1];
        alu_c_s   = shr_s[0];
      end
      OP_ASR: begin
        alu_res_s = asr_s[BW:1];
        alu_c_s   = asr_s[0];
      end
      OP_ADC: begin
        alu_res_s = adc_s[BW-1:0];
        alu_c_s   = adc_s[BW];
        alu_v_s   = add_ovf(bus.in_a[BW-1], bus.in_b[BW-1], adc_s[BW-1]);
      end
      default: begin
        alu_res_s = {BW{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
      end
    endcase
  end

  // Pick the value to load: the finished product or the single-cycle result.
  always_comb begin
    load_res_s   = alu_res_s;
    load_flags_s = pack_flags(alu_c_s, alu_v_s, alu_res_s);
    if (mul_load_s) begin
      load_res_s   = acc_r[BW-1:0];
      load_flags_s = pack_flags(1'b0, |acc_r[2*BW-1:BW], acc_r[BW-1:0]);
    end else begin
      load_res_s   = alu_res_s;
      load_flags_s = pack_flags(alu_c_s, alu_v_s, alu_res_s);
    end
  end

  // Next-state logic: enter MUL on an accepted multiply, leave when the product loads.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (bus.opcode == OP_MUL)) begin
          state_nx_s = MUL;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MUL: begin
        if (mul_load_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = MUL;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Shift-add multiplier: one partial product per cycle over BW cycles, then a
  // done cycle where the product waits to enter the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= {(2*BW){1'b0}};
      mcand_r  <= {(2*BW){1'b0}};
      mplier_r <= {BW{1'b0}};
      cnt_r    <= {SW{1'b0}};
      done_r   <= 1'b0;
    end else if (accept_s && (bus.opcode == OP_MUL)) begin
      acc_r    <= {(2*BW){1'b0}};
      mcand_r  <= {{BW{1'b0}}, bus.in_a};
      mplier_r <= bus.in_b;
      cnt_r    <= {SW{1'b0}};
      done_r   <= 1'b0;
    end else if ((state_r == MUL) && !done_r) begin
      acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {(2*BW){1'b0}});
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      if (cnt_r == CNT_LAST) begin
        done_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + {{(SW-1){1'b0}}, 1'b1};
      end
    end else if (mul_load_s) begin
      cnt_r  <= {SW{1'b0}};
      done_r <= 1'b0;
    end
  end

  // Result register: load a new result, otherwise drop valid once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r       <= {BW{1'b0}};
      flags_r     <= 4'b0000;
      out_valid_r <= 1'b0;
      carry_q_r   <= 1'b0;
    end else if (load_s) begin
      out_r       <= load_res_s;
      flags_r     <= load_flags_s;
      out_valid_r <= 1'b1;
      carry_q_r   <= load_flags_s[3];
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out       = out_r;
  assign bus.flags     = flags_r;
  assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at BW=16 with hand-computed expected values.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  seq_alu_if #(.BW(16)) bus ();

  seq_alu #(.BW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single edge; expects in_ready to be high.
  task automatic issue(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.opcode   = opc;
    bus.in_a     = a;
    bus.in_b     = b;
    chk("issue_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Issue a single-cycle op and check the result one edge later.
  task automatic op1(input string tag, input logic [3:0] opc, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] eo, input logic [3:0] ef);
    issue(opc, a, b);
    chk({tag, "_out"},   {16'd0, bus.out},         {16'd0, eo});
    chk({tag, "_flags"}, {28'd0, bus.flags},       {28'd0, ef});
    chk({tag, "_vld"},   {31'd0, bus.out_valid},   32'd1);
  endtask

  // Issue a multiply and wait (bounded) for its result.
  task automatic mul_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eo, input logic [3:0] ef);
    int k;
    issue(4'd8, a, b);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_vld"},   {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_out"},   {16'd0, bus.out},       {16'd0, eo});
    chk({tag, "_flags"}, {28'd0, bus.flags},     {28'd0, ef});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'h0000;
    bus.in_b      = 16'h0000;
    bus.opcode    = 4'd0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_out",   {16'd0, bus.out},       32'd0);
    chk("rst_flags", {28'd0, bus.flags},     32'd0);
    chk("rst_vld",   {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b0;
    chk("rst_rdy",   {31'd0, bus.in_ready},  32'd1);

    // Arithmetic and carry chain
    op1("add_ovf", 4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b0110);
    op1("sub_brw", 4'd1,  16'h0003, 16'h0005, 16'hFFFE, 4'b1010);
    op1("add_cry", 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b1001);
    op1("adc",     4'd12, 16'h0001, 16'h0001, 16'h0003, 4'b0000);
    op1("adc_nc",  4'd12, 16'h0001, 16'h0001, 16'h0002, 4'b0000);
    op1("sub_vf",  4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0100);
    op1("inc_w",   4'd5,  16'hFFFF, 16'h1234, 16'h0000, 4'b1001);
    op1("inc_v",   4'd5,  16'h7FFF, 16'h0000, 16'h8000, 4'b0110);
    // Logic and pass
    op1("and",     4'd2,  16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000);
    op1("or",      4'd3,  16'hF000, 16'h000F, 16'hF00F, 4'b0010);
    op1("xor",     4'd4,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001);
    op1("pass_a",  4'd6,  16'h1357, 16'h9BDF, 16'h1357, 4'b0000);
    op1("pass_b",  4'd7,  16'h1357, 16'h9BDF, 16'h9BDF, 4'b0010);
    // Shifts, including ignored upper shift bits and zero shift
    op1("shl",     4'd9,  16'h8001, 16'h0001, 16'h0002, 4'b1000);
    op1("shl_0",   4'd9,  16'h8000, 16'h0010, 16'h8000, 4'b0010);
    op1("shr",     4'd10, 16'h0003, 16'hFFF1, 16'h0001, 4'b1000);
    op1("asr_c",   4'd11, 16'h8008, 16'h0004, 16'hF800, 4'b1010);
    op1("op13",    4'd13, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0001);
    op1("op15",    4'd15, 16'h1234, 16'h5678, 16'h0000, 4'b0001);

    // Valid drops once consumed with nothing new
    tick();
    chk("vld_clr", {31'd0, bus.out_valid}, 32'd0);

    // Multiply latency and in_ready blackout
    issue(4'd8, 16'h0100, 16'h0100);
    for (int k = 1; k <= 16; k++) begin
      chk("mul_rdy", {31'd0, bus.in_ready},  32'd0);
      chk("mul_vld", {31'd0, bus.out_valid}, 32'd0);
      tick();
    end
    chk("mul_vld16", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("mul_vld17",   {31'd0, bus.out_valid}, 32'd1);
    chk("mul_out",     {16'd0, bus.out},       32'd0);
    chk("mul_flags",   {28'd0, bus.flags},     {28'd0, 4'b0101});
    mul_op("mul_ff",   16'h00FF, 16'h00FF, 16'hFE01, 4'b0010);
    mul_op("mul_hi",   16'h1234, 16'h0010, 16'h2340, 4'b0100);
    mul_op("mul_0",    16'h0000, 16'hBEEF, 16'h0000, 4'b0001);
    tick();

    // Backpressure: result held, pending op waits, then accepted on release
    bus.out_ready = 1'b0;
    op1("bp_add", 4'd0, 16'h0002, 16'h0003, 16'h0005, 4'b0000);
    bus.in_valid = 1'b1;
    bus.opcode   = 4'd4;
    bus.in_a     = 16'h00F0;
    bus.in_b     = 16'h0FF0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rdy", {31'd0, bus.in_ready},  32'd0);
      chk("bp_out", {16'd0, bus.out},       32'h0005);
      chk("bp_vld", {31'd0, bus.out_valid}, 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_new_out", {16'd0, bus.out},       32'h0F00);
    chk("bp_new_vld", {31'd0, bus.out_valid}, 32'd1);
    tick();
    chk("bp_drain",   {31'd0, bus.out_valid}, 32'd0);

    // Reset in the middle of a multiply
    issue(4'd8, 16'h0003, 16'h0005);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_vld",   {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_out",   {16'd0, bus.out},       32'd0);
    chk("mrst_flags", {28'd0, bus.flags},     32'd0);
    tick();
    rst = 1'b0;
    chk("mrst_rdy",   {31'd0, bus.in_ready},  32'd1);
    for (int k = 0; k < 20; k++) begin
      tick();
    end
    chk("mrst_noout", {31'd0, bus.out_valid}, 32'd0);
    op1("asr", 4'd11, 16'h8000, 16'h0004, 16'hF800, 4'b0010);
    op1("adc_clr", 4'd12, 16'h0001, 16'h0001, 16'h0002, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
